// File: rtl/siso_iter_ctrl.sv
// siso_iter_ctrl: runs the shared SISO core through 2*n_iter half-iterations,
// alternating natural and QPP order, and steers extrinsics back to the a-priori buffer.
module siso_iter_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int ITER_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_blklen,
  input  logic [ITER_W-1:0] i_n_iter,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_cfg,
  output logic [ITER_W:0]   o_half_idx,
  output logic              o_il_mode,
  output logic              o_rd_en,
  output logic              o_rd_sel,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_apr_rd_en,
  output logic [ADDR_W-1:0] o_apr_rd_addr,
  output logic [15:0]       o_siso_blklen,
  output logic              o_siso_valid_blklen,
  input  logic              i_siso_ready,
  output logic              o_siso_valid_in,
  output logic              o_siso_valid_apriori,
  input  logic              i_siso_valid_extrinsic,
  output logic              o_ext_wr_en,
  output logic [ADDR_W-1:0] o_ext_wr_addr
);

  if (DATA_W < 1 || ADDR_W < 13) begin : g_param_check
    $error("siso_iter_ctrl: DATA_W must be >= 1 and ADDR_W must hold 6144");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG      = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [15:0]       r_k;
  logic [ITER_W-1:0] r_n_iter;
  logic [ITER_W:0]   r_half;
  logic              r_phase;
  logic [ADDR_W-1:0] r_kcnt;
  logic [ADDR_W-1:0] r_ext_cnt;
  logic              r_valid_in;
  logic              r_valid_apr;
  logic              r_err_cfg;

  logic              w_cfg_ok;
  logic              w_accept;
  logic [ADDR_W-1:0] w_k_last;
  logic              w_stream_last;
  logic              w_ext_full;
  logic              w_half_last;
  logic              w_rd_en;
  logic              w_apr_rd_en;
  logic              w_ext_wr_en;

  assign w_cfg_ok      = (i_blklen >= 16'd40) && (i_blklen <= 16'd6144) &&
                         (i_blklen[2:0] == 3'd0) && (i_n_iter != {ITER_W{1'b0}});
  assign w_accept      = (r_state == S_IDLE) && i_start && w_cfg_ok && !i_abort;
  assign w_k_last      = ADDR_W'(r_k) - ADDR_W'(1);
  assign w_stream_last = r_phase && (r_kcnt == w_k_last);
  assign w_ext_full    = (16'(r_ext_cnt) == r_k);
  assign w_half_last   = (r_half == ({r_n_iter, 1'b0} - (ITER_W+1)'(1)));
  assign w_rd_en       = (r_state == S_STREAM);
  assign w_apr_rd_en   = w_rd_en && !r_phase;
  // Extrinsics are written in the same cycle they arrive; surplus pulses past K are dropped.
  assign w_ext_wr_en   = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                         i_siso_valid_extrinsic && !w_ext_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     w_state_nxt = w_accept ? S_CFG : S_IDLE;
        S_CFG:      w_state_nxt = S_WAIT_RDY;
        S_WAIT_RDY: w_state_nxt = i_siso_ready ? S_STREAM : S_WAIT_RDY;
        S_STREAM:   w_state_nxt = w_stream_last ? S_DRAIN : S_STREAM;
        S_DRAIN:    w_state_nxt = w_ext_full ? S_NEXT : S_DRAIN;
        S_NEXT:     w_state_nxt = w_half_last ? S_DONE : S_CFG;
        S_DONE:     w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_k         <= 16'd0;
      r_n_iter    <= {ITER_W{1'b0}};
      r_half      <= {(ITER_W+1){1'b0}};
      r_phase     <= 1'b0;
      r_kcnt      <= {ADDR_W{1'b0}};
      r_ext_cnt   <= {ADDR_W{1'b0}};
      r_valid_in  <= 1'b0;
      r_valid_apr <= 1'b0;
      r_err_cfg   <= 1'b0;
    end else begin
      r_err_cfg   <= (r_state == S_IDLE) && i_start && !w_cfg_ok && !i_abort;
      // Buffer read latency is one cycle; an abort kills the word in flight.
      r_valid_in  <= w_rd_en && !i_abort;
      r_valid_apr <= w_apr_rd_en && !i_abort;
      if (w_accept) begin
        r_k      <= i_blklen;
        r_n_iter <= i_n_iter;
        r_half   <= {(ITER_W+1){1'b0}};
      end else if ((r_state == S_NEXT) && !w_half_last && !i_abort) begin
        r_half <= r_half + (ITER_W+1)'(1);
      end
      if (r_state == S_CFG) begin
        r_phase   <= 1'b0;
        r_kcnt    <= {ADDR_W{1'b0}};
        r_ext_cnt <= {ADDR_W{1'b0}};
      end else begin
        if (r_state == S_STREAM) begin
          r_phase <= !r_phase;
          if (r_phase) begin
            r_kcnt <= r_kcnt + ADDR_W'(1);
          end
        end
        if (w_ext_wr_en) begin
          r_ext_cnt <= r_ext_cnt + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_busy               = (r_state != S_IDLE);
    o_done               = (r_state == S_DONE);
    o_err_cfg            = r_err_cfg;
    o_half_idx           = r_half;
    o_il_mode            = r_half[0];
    o_rd_en              = w_rd_en;
    o_rd_sel             = w_rd_en && r_phase;
    o_rd_addr            = r_kcnt;
    o_apr_rd_en          = w_apr_rd_en;
    o_apr_rd_addr        = r_kcnt;
    o_siso_blklen        = r_k;
    o_siso_valid_blklen  = (r_state == S_CFG);
    o_siso_valid_in      = r_valid_in;
    o_siso_valid_apriori = r_valid_apr;
    o_ext_wr_en          = w_ext_wr_en;
    o_ext_wr_addr        = r_ext_cnt;
  end

endmodule

// File: tb/tb_siso_iter_ctrl.sv
// Randomized bench for siso_iter_ctrl: every frame is scored cycle by cycle against a
// schedule derived from K, n_iter and the bench's own ready/extrinsic stimulus.
`timescale 1ns/1ps
module tb_siso_iter_ctrl;
  localparam int ADDR_W = 13;
  localparam int ITER_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, siso_ready, siso_vext;
  logic [15:0]       blklen;
  logic [ITER_W-1:0] n_iter;
  logic              busy, done, err_cfg, il_mode, rd_en, rd_sel, apr_rd_en;
  logic              siso_vblk, siso_vin, siso_vapr, ext_wr_en;
  logic [ITER_W:0]   half_idx;
  logic [ADDR_W-1:0] rd_addr, apr_rd_addr, ext_wr_addr;
  logic [15:0]       siso_blklen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  siso_iter_ctrl #(.DATA_W(16), .ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_blklen(blklen), .i_n_iter(n_iter),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_err_cfg(err_cfg),
    .o_half_idx(half_idx), .o_il_mode(il_mode), .o_rd_en(rd_en), .o_rd_sel(rd_sel),
    .o_rd_addr(rd_addr), .o_apr_rd_en(apr_rd_en), .o_apr_rd_addr(apr_rd_addr),
    .o_siso_blklen(siso_blklen), .o_siso_valid_blklen(siso_vblk), .i_siso_ready(siso_ready),
    .o_siso_valid_in(siso_vin), .o_siso_valid_apriori(siso_vapr),
    .i_siso_valid_extrinsic(siso_vext), .o_ext_wr_en(ext_wr_en), .o_ext_wr_addr(ext_wr_addr)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled mid-cycle.
  task automatic drive(input bit st, input bit rdy, input bit vext, input bit ab, input bit rs);
    @(posedge clk);
    #1;
    start = st; siso_ready = rdy; siso_vext = vext; abort = ab; rst = rs;
    #4;
  endtask

  // w is the stream word index of this cycle (-1: none); half < 0 skips the index checks.
  task automatic chk_cyc(input string ph, input int bsy, input int dn, input int vblk, input int w,
                         input int vin, input int vapr, input int wr, input int waddr, input int half);
    chk_eq({ph, ".busy"}, busy, bsy);
    chk_eq({ph, ".done"}, done, dn);
    chk_eq({ph, ".err_cfg"}, err_cfg, 0);
    chk_eq({ph, ".valid_blklen"}, siso_vblk, vblk);
    chk_eq({ph, ".rd_en"}, rd_en, (w >= 0) ? 1 : 0);
    chk_eq({ph, ".apr_rd_en"}, apr_rd_en, (w >= 0 && w % 2 == 0) ? 1 : 0);
    if (w >= 0) begin
      chk_eq({ph, ".rd_sel"}, rd_sel, w % 2);
      chk_eq({ph, ".rd_addr"}, rd_addr, w / 2);
      if (w % 2 == 0) chk_eq({ph, ".apr_rd_addr"}, apr_rd_addr, w / 2);
    end
    chk_eq({ph, ".valid_in"}, siso_vin, vin);
    chk_eq({ph, ".valid_apriori"}, siso_vapr, vapr);
    chk_eq({ph, ".ext_wr_en"}, ext_wr_en, wr);
    if (wr != 0) chk_eq({ph, ".ext_wr_addr"}, ext_wr_addr, waddr);
    if (half >= 0) begin
      chk_eq({ph, ".half_idx"}, half_idx, half);
      chk_eq({ph, ".il_mode"}, il_mode, half % 2);
    end
  endtask

  task automatic chk_zero(input string ph);
    chk_eq({ph, ".busy"}, busy, 0);
    chk_eq({ph, ".done"}, done, 0);
    chk_eq({ph, ".err_cfg"}, err_cfg, 0);
    chk_eq({ph, ".half_idx"}, half_idx, 0);
    chk_eq({ph, ".il_mode"}, il_mode, 0);
    chk_eq({ph, ".rd_en"}, rd_en, 0);
    chk_eq({ph, ".rd_sel"}, rd_sel, 0);
    chk_eq({ph, ".rd_addr"}, rd_addr, 0);
    chk_eq({ph, ".apr_rd_en"}, apr_rd_en, 0);
    chk_eq({ph, ".apr_rd_addr"}, apr_rd_addr, 0);
    chk_eq({ph, ".siso_blklen"}, siso_blklen, 0);
    chk_eq({ph, ".valid_blklen"}, siso_vblk, 0);
    chk_eq({ph, ".valid_in"}, siso_vin, 0);
    chk_eq({ph, ".valid_apriori"}, siso_vapr, 0);
    chk_eq({ph, ".ext_wr_en"}, ext_wr_en, 0);
    chk_eq({ph, ".ext_wr_addr"}, ext_wr_addr, 0);
  endtask

  task automatic after_cut(input bit was_rst);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    if (was_rst) chk_zero("rst_mid");
    else chk_cyc("abort.next", 0, 0, 0, -1, 0, 0, 0, 0, -1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_cyc("abort.idle", 0, 0, 0, -1, 0, 0, 0, 0, -1);
  endtask

  task automatic bad_cfg(input int k, input int ni);
    blklen = 16'(k); n_iter = ITER_W'(ni);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_cyc("bad.req", 0, 0, 0, -1, 0, 0, 0, 0, -1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_eq("bad.err_cfg", err_cfg, 1);
    chk_eq("bad.busy", busy, 0);
    chk_eq("bad.valid_blklen", siso_vblk, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_cyc("bad.after", 0, 0, 0, -1, 0, 0, 0, 0, -1);
  endtask

  // cut: 0 none, 1 abort+start in first DRAIN cycle, 2 abort at word cut_n, 3 reset at word cut_n
  task automatic run_frame(input int k, input int ni, input int rdy_hold, input int rdy_pct,
                           input int ext_pct, input int cut, input int cut_n);
    int ecnt, wait_n, dr_n;
    bit r, p, ab, last, hit;
    blklen = 16'(k); n_iter = ITER_W'(ni);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cyc("req", 0, 0, 0, -1, 0, 0, 0, 0, -1);
    for (int h = 0; h < 2 * ni; h++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk_cyc("cfg", 1, 0, 1, -1, 0, 0, 0, 0, h);
      chk_eq("cfg.siso_blklen", siso_blklen, k);
      wait_n = 0;
      do begin
        r = (wait_n >= rdy_hold) &&
            (($urandom_range(99) < rdy_pct) || (wait_n >= rdy_hold + 30));
        drive(1'b0, r, 1'b1, 1'b0, 1'b1);
        chk_cyc("wait", 1, 0, 0, -1, 0, 0, 0, 0, h);
        wait_n++;
      end while (!r);
      ecnt = 0;
      for (int n = 0; n < 2 * k; n++) begin
        p = ($urandom_range(99) < ext_pct);
        hit = (h == 0) && (n == cut_n);
        drive(1'b0, 1'($urandom_range(1)), p, (cut == 2) && hit, !((cut == 3) && hit));
        chk_cyc("stream", 1, 0, 0, n, (n > 0), (n % 2 == 1), (p && ecnt < k), ecnt, h);
        if (p && ecnt < k) ecnt++;
        if (cut >= 2 && hit) begin
          after_cut(cut == 3);
          return;
        end
      end
      dr_n = 0;
      do begin
        last = (ecnt == k);
        p = ($urandom_range(99) < ext_pct) || (dr_n > 20);
        ab = (cut == 1) && (h == 0) && (dr_n == 0);
        drive(ab, 1'b1, p, ab, 1'b1);
        chk_cyc("drain", 1, 0, 0, -1, (dr_n == 0), 0, (p && ecnt < k), ecnt, h);
        if (p && ecnt < k) ecnt++;
        if (ab) begin
          after_cut(1'b0);
          return;
        end
        dr_n++;
      end while (!last);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_cyc("next", 1, 0, 0, -1, 0, 0, 0, 0, h);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cyc("done", 1, 1, 0, -1, 0, 0, 0, 0, 2 * ni - 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cyc("idle", 0, 0, 0, -1, 0, 0, 0, 0, 2 * ni - 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; siso_ready = 1'b0; siso_vext = 1'b0;
    blklen = 16'd0; n_iter = {ITER_W{1'b0}};
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_zero("reset");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_zero("reset.idle");

    bad_cfg(44, 1);
    bad_cfg(6152, 2);
    bad_cfg(40, 0);
    bad_cfg(32, 1);

    run_frame(40, 1, 0, 100, 100, 0, 0);
    run_frame(40, 1, 50, 40, 60, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_frame(8 * $urandom_range(5, 25), $urandom_range(1, 3), $urandom_range(0, 3),
                $urandom_range(20, 100), $urandom_range(30, 100), 0, 0);
    end
    run_frame(40, 15, 0, 100, 100, 0, 0);
    run_frame(56, 2, 0, 100, 70, 1, 0);
    run_frame(48, 1, 1, 100, 70, 2, 7);
    run_frame(64, 2, 0, 100, 70, 3, 11);
    run_frame(40, 1, 0, 100, 80, 0, 0);
    run_frame(6144, 1, 0, 100, 50, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/siso_iter_ctrl.md
# siso_iter_ctrl

Iteration scheduler for the shared max-log-MAP SISO decoder core. It accepts a frame descriptor (block length, iteration count) and runs the one SISO instance through 2·n_iter half-iterations, alternating natural order (SISO1) and QPP-interleaved order (SISO2). For each half-iteration it configures the core, streams systematic/parity/a-priori words from the frame buffers, and writes the returned extrinsic values back to the a-priori buffer. It sits between the frame buffers / QPP address unit and the SISO core.

## Interface

- DATA_W, 16, soft-value width (informational; controller moves no data)
- ADDR_W, 13, buffer address width (≥ log2(6144)+1)
- ITER_W, 4, width of iteration count

- clk  in  1  single clock domain
- rst  in  1  synchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- blklen  in  16  block length K, sampled with start
- n_iter  in  ITER_W  full iterations, sampled with start
- abort  in  1  return to IDLE next cycle
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse on frame completion
- err_cfg  out  1  1-cycle pulse on rejected start
- half_idx  out  ITER_W+1  current half-iteration index
- il_mode  out  1  half_idx[0]; 1 = QPP-interleaved addressing
- rd_en  out  1  read strobe to sys/parity buffer
- rd_sel  out  1  0 = systematic word, 1 = parity word
- rd_addr  out  ADDR_W  linear index k (QPP unit maps it when il_mode=1)
- apr_rd_en  out  1  read strobe to a-priori buffer
- apr_rd_addr  out  ADDR_W  linear index k
- siso_blklen  out  16  block length to core
- siso_valid_blklen  out  1  1-cycle configuration strobe
- siso_ready  in  1  core ready for a new block
- siso_valid_in  out  1  data word valid (buffer data, 1-cycle read latency)
- siso_valid_apriori  out  1  a-priori word valid
- siso_valid_extrinsic  in  1  extrinsic word from core
- ext_wr_en  out  1  write strobe to a-priori buffer
- ext_wr_addr  out  ADDR_W  linear extrinsic index

## Operation

- States: IDLE, CFG, WAIT_RDY, STREAM, DRAIN, NEXT, DONE.
- IDLE: start=1 with legal config → latch K and n_iter, half_idx=0, go CFG. Legal: 40 ≤ K ≤ 6144, K mod 8 = 0, n_iter ≠ 0. Illegal → err_cfg pulse, stay IDLE.
- CFG (1 cycle): siso_blklen=K, siso_valid_blklen=1; clear stream and extrinsic counters → WAIT_RDY.
- WAIT_RDY: stay until siso_ready=1 → STREAM.
- STREAM: 2K cycles, phase bit p alternates starting at 0, k increments after p=1. p=0: rd_en=1, rd_sel=0, apr_rd_en=1, rd_addr=apr_rd_addr=k. p=1: rd_en=1, rd_sel=1, apr_rd_en=0. After word 2K-1 → DRAIN.
- siso_valid_in = rd_en delayed 1 cycle; siso_valid_apriori = apr_rd_en delayed 1 cycle.
- Extrinsic capture active in STREAM and DRAIN: each siso_valid_extrinsic → ext_wr_en=1 same cycle (combinational), ext_wr_addr=ext_cnt, ext_cnt++. Pulses once ext_cnt=K are ignored (no write).
- DRAIN: wait until ext_cnt=K → NEXT.
- NEXT (1 cycle): if half_idx = 2·n_iter−1 → DONE, else half_idx++ → CFG.
- DONE: done=1 one cycle → IDLE. half_idx retains final value.
- abort=1 in any state: next state IDLE, all strobes low next cycle, no done. Overrides start.
- start in any non-IDLE state is ignored.

## Timing

- Reset (rst=0 at a clk edge): state IDLE; every output 0 (busy, done, err_cfg, half_idx, il_mode, rd_*, apr_*, siso_*, ext_*).
- start accepted at edge t: CFG during cycle t+1, WAIT_RDY from t+2.
- siso_ready sampled 1 at edge r: first rd_en in cycle r+1, first siso_valid_in in r+2.
- Half-iteration with zero core latency beyond stream: 1 (CFG) + ≥1 (WAIT_RDY) + 2K (STREAM) + drain + 1 (NEXT).
- Extrinsic count reaching K during last STREAM cycle: DRAIN lasts exactly 1 cycle.
- siso_valid_in/siso_valid_apriori remain 1 cycle delayed even across the STREAM→DRAIN transition (last valid appears in the first DRAIN cycle).

## Test plan

- Reset mid-STREAM (rst low for 1 edge) → all outputs 0 next cycle; state IDLE; a subsequent start runs normally.
- K=40, n_iter=1, siso_ready tied 1, core model returns 40 extrinsic pulses → two half-iterations, 80 rd_en each, 40 apr_rd_en; il_mode 0 then 1; ext_wr_addr 0..39; single done pulse.
- K=6144, n_iter=4 → 8 CFG strobes with siso_blklen=6144; rd_addr wraps 0..6143 each half; done after half_idx=7.
- Illegal configs K=44, K=6152, n_iter=0 → err_cfg pulse each, busy stays 0, no siso_valid_blklen.
- siso_ready held 0 for 50 cycles after CFG → no rd_en until ready; 42 extrinsic pulses for K=40 → only 40 writes.
- abort asserted in DRAIN with start simultaneously high → IDLE next cycle, no done, start ignored.
